// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RiSC-16 datapath.
// Walks each instruction through fetch, decode, execute, optional memory and
// write-back states. It handshakes with variable-latency instruction and data
// memories, counts retired instructions and traps memory timeouts.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      ir,
  input  logic             eq_out,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             we_mem,
  output logic             we_reg,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ADD,
  output logic             NAND,
  output logic             PASS1,
  output logic             EQ,
  output logic             BR,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired,
  output logic             halted,
  output logic             err
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StError  = 3'd6
  } state_e;

  localparam logic [2:0] OpNand = 3'b010;
  localparam logic [2:0] OpLui  = 3'b011;
  localparam logic [2:0] OpSw   = 3'b100;
  localparam logic [2:0] OpLw   = 3'b101;
  localparam logic [2:0] OpBeq  = 3'b110;
  localparam logic [2:0] OpJalr = 3'b111;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbMem  = 2'd1;
  localparam logic [1:0] WbPc1  = 2'd2;
  localparam logic [1:0] PcInc  = 2'd0;
  localparam logic [1:0] PcBr   = 2'd1;
  localparam logic [1:0] PcReg  = 2'd2;

  // The wait counter only has to hold 0 .. MEM_TIMEOUT-1.
  localparam bit          TimeoutEn = (MEM_TIMEOUT != 0);
  localparam int unsigned WaitW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = TimeoutEn ? WaitW'(MEM_TIMEOUT - 1) : '0;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [RET_W-1:0]   retired_q, retired_d;

  logic [2:0]         opcode;
  logic [6:0]         imm7;
  logic [3:0]         alu_sel;
  logic               timeout_hit;
  logic               retire;
  logic               unused_ir;

  assign opcode      = ir[15:13];
  assign imm7        = ir[6:0];
  assign unused_ir   = ^ir[12:7];
  assign timeout_hit = TimeoutEn && (wait_q == WaitLast);

  // ALU function select per opcode, as {ADD, NAND, PASS1, EQ}.
  always_comb begin
    alu_sel = 4'b1000;
    unique case (opcode)
      OpNand:  alu_sel = 4'b0100;
      OpLui:   alu_sel = 4'b0010;
      OpBeq:   alu_sel = 4'b0001;
      default: alu_sel = 4'b1000;
    endcase
  end

  // Next-state, wait counter and control outputs; reset forces every output low.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    we_mem   = 1'b0;
    we_reg   = 1'b0;
    wb_sel   = WbAlu;
    pc_we    = 1'b0;
    pc_sel   = PcInc;
    BR       = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    {ADD, NAND, PASS1, EQ} = 4'b0000;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StError;
        end else if (TimeoutEn) begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        // JALR with a non-zero immediate is the HALT encoding.
        state_d = ((opcode == OpJalr) && (imm7 != 7'd0)) ? StHalt : StExec;
      end
      StExec: begin
        {ADD, NAND, PASS1, EQ} = alu_sel;
        unique case (opcode)
          OpBeq: begin
            pc_we   = 1'b1;
            pc_sel  = eq_out ? PcBr : PcInc;
            BR      = eq_out;
            retire  = 1'b1;
            state_d = StFetch;
            wait_d  = '0;
          end
          OpJalr: begin
            we_reg  = 1'b1;
            wb_sel  = WbPc1;
            pc_we   = 1'b1;
            pc_sel  = PcReg;
            retire  = 1'b1;
            state_d = StFetch;
            wait_d  = '0;
          end
          OpSw, OpLw: begin
            state_d = StMem;
            wait_d  = '0;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        {ADD, NAND, PASS1, EQ} = alu_sel;
        dmem_req = 1'b1;
        we_mem   = (opcode == OpSw);
        if (dmem_ack) begin
          if (opcode == OpSw) begin
            pc_we   = 1'b1;
            pc_sel  = PcInc;
            retire  = 1'b1;
            state_d = StFetch;
            wait_d  = '0;
          end else begin
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          state_d = StError;
        end else if (TimeoutEn) begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWb: begin
        {ADD, NAND, PASS1, EQ} = alu_sel;
        we_reg  = 1'b1;
        wb_sel  = (opcode == OpLw) ? WbMem : WbAlu;
        pc_we   = 1'b1;
        pc_sel  = PcInc;
        retire  = 1'b1;
        state_d = StFetch;
        wait_d  = '0;
      end
      StHalt:  halted = 1'b1;
      StError: err    = 1'b1;
      default: state_d = StError;
    endcase

    if (reset) begin
      retire   = 1'b0;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      we_mem   = 1'b0;
      we_reg   = 1'b0;
      wb_sel   = WbAlu;
      pc_we    = 1'b0;
      pc_sel   = PcInc;
      BR       = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
      {ADD, NAND, PASS1, EQ} = 4'b0000;
    end
  end

  // Retired count advances on the same edge as the retiring PC write; wraps naturally.
  always_comb begin
    retired_d = retired_q;
    if (retire) begin
      retired_d = retired_q + RET_W'(1);
    end
  end

  // State, wait counter and retired counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Debug/status views read as zero while reset is held.
  assign state   = reset ? 3'd0 : state_q;
  assign retired = reset ? '0 : retired_q;

endmodule
